// File: rtl/fifo_wr_ptr.sv
// Write-domain pointer/flag controller for the dual-clock FIFO: binary address,
// Gray pointer to the read side, full/almost-full/level/overflow status.
module fifo_wr_ptr #(
  parameter int ADDR_WIDTH       = 4,
  parameter int ALMOST_FULL_DIFF = 2,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr,
  input  logic [ADDR_WIDTH:0]   rd_ptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = PW'(DEPTH - ALMOST_FULL_DIFF);

  logic [ADDR_WIDTH:0] sync_reg [SYNC_STAGES];
  logic [ADDR_WIDTH:0] rq;
  logic [ADDR_WIDTH:0] rq_bin;
  logic [ADDR_WIDTH:0] wr_ptr_bin_reg;
  logic [ADDR_WIDTH:0] wr_ptr_bin_next;
  logic [ADDR_WIDTH:0] gray_next;
  logic [ADDR_WIDTH:0] full_pattern;
  logic [ADDR_WIDTH:0] diff_next;
  logic                full_next;
  logic                almost_full_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
    end else begin
      sync_reg[0] <= rd_ptr;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  assign rq = sync_reg[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  generate
    for (genvar gi = 0; gi <= ADDR_WIDTH; gi++) begin : g_rq_bin
      assign rq_bin[gi] = ^rq[ADDR_WIDTH:gi];
    end
  endgenerate

  // Reset gates the strobe so no memory write lands while state is clearing.
  assign wr_en           = write & ~full & ~reset;
  assign wr_ptr_bin_next = wr_ptr_bin_reg + PW'(wr_en);
  assign gray_next       = (wr_ptr_bin_next >> 1) ^ wr_ptr_bin_next;
  assign full_pattern    = {~rq[ADDR_WIDTH:ADDR_WIDTH-1], rq[ADDR_WIDTH-2:0]};
  assign full_next       = (gray_next == full_pattern);
  assign diff_next       = wr_ptr_bin_next - rq_bin;
  assign almost_full_next = (diff_next >= AF_LEVEL);
  assign wr_addr         = wr_ptr_bin_reg[ADDR_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_bin_reg <= '0;
      wr_ptr         <= '0;
      full           <= 1'b0;
      almost_full    <= 1'b0;
      level          <= '0;
      overflow       <= 1'b0;
    end else begin
      wr_ptr_bin_reg <= wr_ptr_bin_next;
      wr_ptr         <= gray_next;
      full           <= full_next;
      almost_full    <= almost_full_next;
      level          <= diff_next;
      if (write && full) overflow <= 1'b1;
    end
  end

endmodule
